// File: rtl/long_mul_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digit encoding
// and the window-to-digit recoding helper.
package mul_pkg;

    localparam int unsigned MUL_XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'b001,
        DIG_ONE  = 3'b010,
        DIG_TWO  = 3'b100
    } booth_mag_e;

    typedef struct packed {
        logic       neg;
        booth_mag_e mag;
    } booth_digit_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}; digit = -2*w2 + w1 + w0.
    function automatic booth_digit_t booth_decode(input logic [2:0] w);
        booth_digit_t d;
        d.neg = w[2] & ~(w[1] & w[0]);
        case (w)
            3'b000, 3'b111: d.mag = DIG_ZERO;
            3'b011, 3'b100: d.mag = DIG_TWO;
            default:        d.mag = DIG_ONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/long_mul_if.sv
// Start/finish handshake bundle shared by the M-extension multiply and divide units.
interface long_mul_if
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = MUL_XLEN
);
    logic            en;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            uns_a;
    logic            uns_b;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi;
    logic            busy;
    logic            fin;

    modport master (output en, a, b, uns_a, uns_b, input lo, hi, busy, fin);
    modport slave  (input en, a, b, uns_a, uns_b, output lo, hi, busy, fin);
endinterface

// File: rtl/long_mul_booth_enc.sv
// Combinational Booth recoder: 3-bit multiplier window to a partial product in
// one's complement form plus the carry-in that completes the negation.
module booth_enc
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = MUL_XLEN
) (
    input  logic [2:0]      win,
    input  logic [XLEN+1:0] a_ext,
    output logic [XLEN+2:0] pp,
    output logic            cin
);
    booth_digit_t    dig;
    logic [XLEN+2:0] sel;

    always_comb begin
        dig = booth_decode(win);
        case (dig.mag)
            DIG_ONE: sel = {a_ext[XLEN+1], a_ext};
            DIG_TWO: sel = {a_ext, 1'b0};
            default: sel = '0;
        endcase
        pp  = dig.neg ? ~sel : sel;
        cin = dig.neg;
    end
endmodule

// File: rtl/long_mul.sv
// Multi-cycle radix-4 Booth multiplier, full 2*XLEN product, en/fin handshake.
// Optional LONG_MUL_EARLY_EXIT_EN finishes as soon as the remaining digits are all zero.
module long_mul
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = MUL_XLEN
) (
    input logic       clk,
    input logic       rst,
    long_mul_if.slave bus
);
    localparam int unsigned NDIG = XLEN / 2 + 1;
    localparam int unsigned EW   = XLEN + 2;
    localparam int unsigned AW   = XLEN + 4;
    localparam int unsigned PW   = XLEN + 3;
    localparam int unsigned CW   = AW + EW;
    localparam int unsigned CNTW = $clog2(NDIG);
    localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);

    state_e          state, state_n;
    logic [EW-1:0]   a_reg, a_reg_n;
    logic [EW-1:0]   mreg, mreg_n;
    logic            bprev, bprev_n;
    logic [AW-1:0]   acc, acc_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [XLEN-1:0] lo_q, lo_n, hi_q, hi_n;
    logic            busy_q, busy_n, fin_q, fin_n;

    logic [PW-1:0]   pp;
    logic            pp_cin;
    logic [AW-1:0]   acc_sum;
    logic [CW-1:0]   run_step, step;
    logic            early;

    booth_enc #(.XLEN(XLEN)) u_enc (
        .win  ({mreg[1:0], bprev}),
        .a_ext(a_reg),
        .pp   (pp),
        .cin  (pp_cin)
    );

    // {acc, mreg} is one product register: consumed multiplier bits leave the
    // bottom while finished product bits enter from acc.
    always_comb begin
        acc_sum  = acc + {pp[PW-1], pp} + AW'(pp_cin);
        run_step = $signed({acc_sum, mreg}) >>> 2;
    end

`ifdef LONG_MUL_EARLY_EXIT_EN
    logic [EW-1:0]   live;
    logic [CNTW+1:0] rem2;
    logic [CW-1:0]   skip_step;

    always_comb begin
        live      = {EW{1'b1}} >> {cnt, 1'b0};
        rem2      = ((CNTW+2)'(NDIG) - (CNTW+2)'(cnt)) << 1;
        skip_step = $signed({acc, mreg}) >>> rem2;
        early     = (((mreg & live) == '0) && !bprev) ||
                    (((mreg | ~live) == '1) && bprev);
        step      = early ? skip_step : run_step;
    end
`else
    always_comb begin
        early = 1'b0;
        step  = run_step;
    end
`endif

    always_comb begin
        state_n = state;
        a_reg_n = a_reg;
        mreg_n  = mreg;
        bprev_n = bprev;
        acc_n   = acc;
        cnt_n   = cnt;
        lo_n    = lo_q;
        hi_n    = hi_q;
        busy_n  = busy_q;
        fin_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    a_reg_n = {{2{~bus.uns_a & bus.a[XLEN-1]}}, bus.a};
                    mreg_n  = {{2{~bus.uns_b & bus.b[XLEN-1]}}, bus.b};
                    bprev_n = 1'b0;
                    acc_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                {acc_n, mreg_n} = step;
                bprev_n         = mreg[1];
                cnt_n           = cnt + CNTW'(1);
                if (early || cnt == LAST) begin
                    {hi_n, lo_n} = step[2*XLEN-1:0];
                    fin_n        = 1'b1;
                    busy_n       = 1'b0;
                    cnt_n        = '0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            mreg   <= '0;
            bprev  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
        end else begin
            a_reg  <= a_reg_n;
            mreg   <= mreg_n;
            bprev  <= bprev_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            lo_q   <= lo_n;
            hi_q   <= hi_n;
            busy_q <= busy_n;
            fin_q  <= fin_n;
        end
    end

    assign bus.lo   = lo_q;
    assign bus.hi   = hi_q;
    assign bus.busy = busy_q;
    assign bus.fin  = fin_q;

endmodule
